// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one asynchronous single-port SRAM between three clients:
//   - histogram increment (read-modify-write, saturating +1)
//   - readout path (single word read)
//   - clear sweep (writes zero to addresses 0..CLR_LAST)
// A single FSM sequences the SRAM strobes. All outputs are registered, so
// every strobe changes only on a rising CLK edge, or asynchronously on reset.
//
// Ports
//   CLK, RSTN               clock, asynchronous active-low reset
//   hist_req/hist_adr       increment request (level) and bin address
//   hist_ack                one-cycle pulse once the increment is written
//   rd_req/rd_adr           readout request (level) and address
//   rd_data/rd_valid        readout word and its one-cycle valid pulse
//   clr_req/clr_busy        clear-sweep start and busy flag
//   sram_adr/sram_dout      SRAM address and write data to the pad driver
//   sram_din                read data from the SRAM pads
//   sram_drv                pad driver enable (1 = drive sram_dout)
//   sram_oe_n/sram_we_n     SRAM output enable and write enable, active-low
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int            AW       = 20,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] CLR_LAST = '1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          hist_req,
  input  logic [AW-1:0] hist_adr,
  output logic          hist_ack,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_adr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic [AW-1:0] sram_adr,
  output logic [DW-1:0] sram_dout,
  input  logic [DW-1:0] sram_din,
  output logic          sram_drv,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  typedef enum logic [3:0] {
    IDLE,
    H_RD0, H_RD1, H_CAP, H_SET, H_WE,
    R_RD0, R_RD1, R_CAP,
    C_SET, C_WE, C_NXT
  } state_t;

  state_t        r_state;
  logic          r_rd_pri;    // 1: readout wins the next hist/rd tie
  logic [DW-1:0] w_inc;       // saturating sram_din + 1
  logic          w_grant_hist;
  logic          w_grant_rd;

  // An all-ones bin stays all-ones instead of wrapping to zero.
  assign w_inc = (sram_din == '1) ? sram_din : sram_din + DW'(1);

  // Round-robin tie break: the client not served last wins the tie.
  assign w_grant_hist = hist_req && (!rd_req || !r_rd_pri);
  assign w_grant_rd   = rd_req && !w_grant_hist;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below sees the pre-edge values of the registers it reads.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= IDLE;
      r_rd_pri  <= 1'b0;
      sram_adr  <= '0;
      sram_dout <= '0;
      sram_drv  <= 1'b0;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      hist_ack  <= 1'b0;
      clr_busy  <= 1'b0;
    end else begin
      hist_ack <= 1'b0;
      rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_drv  <= 1'b0;
          if (clr_req) begin
            r_state   <= C_SET;
            sram_adr  <= '0;
            sram_dout <= '0;
            sram_drv  <= 1'b1;
            clr_busy  <= 1'b1;
          end else if (w_grant_hist) begin
            r_state   <= H_RD0;
            sram_adr  <= hist_adr;
            sram_oe_n <= 1'b0;
            r_rd_pri  <= 1'b1;
          end else if (w_grant_rd) begin
            r_state   <= R_RD0;
            sram_adr  <= rd_adr;
            sram_oe_n <= 1'b0;
            r_rd_pri  <= 1'b0;
          end
        end
        // Histogram read-modify-write. Read data is sampled at the end of
        // H_CAP, the third cycle with oe_n low; the driver turns on in the
        // same edge that releases oe_n, so the two never overlap.
        H_RD0: r_state <= H_RD1;
        H_RD1: r_state <= H_CAP;
        H_CAP: begin
          r_state   <= H_SET;
          sram_dout <= w_inc;
          sram_oe_n <= 1'b1;
          sram_drv  <= 1'b1;
        end
        H_SET: begin
          r_state   <= H_WE;
          sram_we_n <= 1'b0;
        end
        H_WE: begin
          // Driver stays on for the IDLE-entry cycle to give data hold
          // after the we_n rising edge.
          r_state   <= IDLE;
          sram_we_n <= 1'b1;
          hist_ack  <= 1'b1;
        end
        // Readout
        R_RD0: r_state <= R_RD1;
        R_RD1: r_state <= R_CAP;
        R_CAP: begin
          r_state   <= IDLE;
          rd_data   <= sram_din;
          rd_valid  <= 1'b1;
          sram_oe_n <= 1'b1;
        end
        // Clear sweep: driver held on with zero data for the whole sweep.
        C_SET: begin
          r_state   <= C_WE;
          sram_we_n <= 1'b0;
        end
        C_WE: begin
          r_state   <= C_NXT;
          sram_we_n <= 1'b1;
        end
        C_NXT: begin
          if (sram_adr == CLR_LAST) begin
            r_state  <= IDLE;
            sram_drv <= 1'b0;
            clr_busy <= 1'b0;
          end else begin
            r_state  <= C_SET;
            sram_adr <= sram_adr + AW'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          sram_drv  <= 1'b0;
          clr_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Directed bench for sram_arbiter with a small behavioural SRAM (256 x 16).
// Single histogram/readout operations come from a vector table; round-robin,
// clear sweep and mid-sequence reset are hand-written sequences. A monitor
// watches the SRAM strobes on every falling edge.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int            AW       = 8;
  localparam int            DW       = 16;
  localparam logic [AW-1:0] CLR_LAST = 8'd15;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b1;
  logic          hist_req = 1'b0;
  logic [AW-1:0] hist_adr = '0;
  logic          hist_ack;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_adr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clr_req = 1'b0;
  logic          clr_busy;
  logic [AW-1:0] sram_adr;
  logic [DW-1:0] sram_dout;
  logic [DW-1:0] sram_din;
  logic          sram_drv;
  logic          sram_oe_n;
  logic          sram_we_n;

  sram_arbiter #(.AW(AW), .DW(DW), .CLR_LAST(CLR_LAST)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .hist_req  (hist_req),
    .hist_adr  (hist_adr),
    .hist_ack  (hist_ack),
    .rd_req    (rd_req),
    .rd_adr    (rd_adr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .sram_adr  (sram_adr),
    .sram_dout (sram_dout),
    .sram_din  (sram_din),
    .sram_drv  (sram_drv),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  always #4 CLK = ~CLK;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem [256];
  logic          ld_en = 1'b0;
  logic          ld_all = 1'b0;
  logic [AW-1:0] ld_adr = '0;
  logic [DW-1:0] ld_data = '0;
  int            wr_count = 0;
  int            zero_wr = 0;
  int            drv_viol = 0;

  // Bus reads back a marker when the SRAM output is disabled.
  assign sram_din = sram_oe_n ? 16'hDEAD : mem[sram_adr];

  always @(posedge CLK) begin
    if (ld_all) begin
      for (int i = 0; i < 256; i++) mem[i] <= ld_data;
    end else if (ld_en) begin
      mem[ld_adr] <= ld_data;
    end
    if (RSTN && !sram_we_n) begin
      if (!sram_drv) drv_viol <= drv_viol + 1;
      mem[sram_adr] <= sram_dout;
      wr_count <= wr_count + 1;
      if (sram_dout == '0) zero_wr <= zero_wr + 1;
    end
  end

  // ---------------- strobe monitor ----------------
  int ovl = 0;
  int we_lo_cnt = 0;
  int hist_acks = 0;
  always @(negedge CLK) begin
    if ((!sram_oe_n && !sram_we_n) || (sram_drv && !sram_oe_n)) ovl <= ovl + 1;
    if (!sram_we_n) we_lo_cnt <= we_lo_cnt + 1;
    if (hist_ack) hist_acks <= hist_acks + 1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic preload(input logic [AW-1:0] adr, input logic [DW-1:0] data);
    @(negedge CLK);
    ld_adr = adr;
    ld_data = data;
    ld_en = 1'b1;
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] data);
    @(negedge CLK);
    ld_data = data;
    ld_all = 1'b1;
    @(negedge CLK);
    ld_all = 1'b0;
  endtask

  // Raise one request and count rising edges until its ack/valid is seen.
  task automatic run_op(input bit is_rd, input logic [AW-1:0] adr, output int lat);
    @(negedge CLK);
    if (is_rd) begin rd_adr = adr; rd_req = 1'b1; end
    else       begin hist_adr = adr; hist_req = 1'b1; end
    lat = 0;
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end while (!(is_rd ? rd_valid : hist_ack) && lat < 30);
    rd_req = 1'b0;
    hist_req = 1'b0;
  endtask

  typedef struct {
    bit            is_rd;
    logic [AW-1:0] adr;
    logic [DW-1:0] pre;
    logic [DW-1:0] exp_mem;
    logic [DW-1:0] exp_rd;
    int            exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, we0, wr0;
    logic [DW-1:0] last_rd;
    logic [3:0] order;
    int n, hc, rc, done_cyc;
    int busy_cnt, fall_cyc, ack_cyc, z0;
    bit ack_in_busy, found;

    vecs[0] = '{1'b0, 8'hA5, 16'h0010, 16'h0011, 16'h0000, 6};
    vecs[1] = '{1'b0, 8'hA5, 16'hFFFF, 16'hFFFF, 16'h0000, 6};
    vecs[2] = '{1'b0, 8'h00, 16'h0000, 16'h0001, 16'h0000, 6};
    vecs[3] = '{1'b0, 8'hFF, 16'hFFFE, 16'hFFFF, 16'h0000, 6};
    vecs[4] = '{1'b1, 8'h20, 16'hBEEF, 16'hBEEF, 16'hBEEF, 4};
    vecs[5] = '{1'b0, 8'h10, 16'h7FFF, 16'h8000, 16'h0000, 6};
    vecs[6] = '{1'b1, 8'hFF, 16'h0001, 16'h0001, 16'h0001, 4};
    vecs[7] = '{1'b0, 8'h21, 16'h00FF, 16'h0100, 16'h0000, 6};

    // ---- reset state ----
    #1 RSTN = 1'b0;
    #2;
    check("rst_strobes", {sram_oe_n, sram_we_n, sram_drv, hist_ack, rd_valid, clr_busy}, 6'b110000);
    check("rst_adr", sram_adr, 0);
    check("rst_dout", sram_dout, 0);
    check("rst_rd_data", rd_data, 0);
    @(negedge CLK);
    RSTN = 1'b1;

    // ---- table-driven single operations ----
    last_rd = '0;
    for (int i = 0; i < 8; i++) begin
      preload(vecs[i].adr, vecs[i].pre);
      we0 = we_lo_cnt;
      wr0 = wr_count;
      run_op(vecs[i].is_rd, vecs[i].adr, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_mem", i), mem[vecs[i].adr], vecs[i].exp_mem);
      if (vecs[i].is_rd) begin
        check($sformatf("v%0d_rd_data", i), rd_data, vecs[i].exp_rd);
        check($sformatf("v%0d_no_write", i), wr_count - wr0, 0);
        last_rd = vecs[i].exp_rd;
      end else begin
        check($sformatf("v%0d_we_low_cycles", i), we_lo_cnt - we0, 1);
      end
    end
    check("rd_data_hold", rd_data, last_rd);

    // ---- round-robin: both held for two services, after a fresh reset ----
    @(negedge CLK) RSTN = 1'b0;
    @(negedge CLK) RSTN = 1'b1;
    preload(8'd1, 16'h0100);
    preload(8'd2, 16'h0200);
    @(negedge CLK);
    hist_adr = 8'd1; rd_adr = 8'd2;
    hist_req = 1'b1; rd_req = 1'b1;
    order = '0; n = 0; hc = 0; rc = 0; done_cyc = -1;
    for (int c = 0; c < 80; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (hist_ack) begin
        if (n < 4) order[n] = 1'b0;
        n++; hc++;
        if (hc == 2) hist_req = 1'b0;
      end
      if (rd_valid) begin
        if (n < 4) order[n] = 1'b1;
        n++; rc++;
        check($sformatf("rr_rd_data_%0d", rc), rd_data, 16'h0200);
        if (rc == 2) rd_req = 1'b0;
      end
      if (hc >= 2 && rc >= 2) begin done_cyc = c + 1; break; end
    end
    hist_req = 1'b0; rd_req = 1'b0;
    check("rr_services", n, 4);
    check("rr_order", order, 4'b1010);
    check("rr_back_to_back_cycles", done_cyc, 20);
    check("rr_hist_word", mem[1], 16'h0102);

    // ---- clear sweep with a histogram request raised mid-sweep ----
    fill(16'h1234);
    z0 = zero_wr; wr0 = wr_count;
    @(negedge CLK) clr_req = 1'b1;
    @(negedge CLK) clr_req = 1'b0;
    busy_cnt = 0; fall_cyc = -1; ack_cyc = -1; ack_in_busy = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (clr_busy) busy_cnt++;
      else if (fall_cyc < 0 && busy_cnt > 0) fall_cyc = c;
      if (hist_ack) begin
        ack_cyc = c;
        if (clr_busy) ack_in_busy = 1'b1;
        hist_req = 1'b0;
      end
      if (busy_cnt == 10 && !hist_req && ack_cyc < 0) begin
        hist_adr = 8'd5;
        hist_req = 1'b1;
      end
      if (ack_cyc >= 0) break;
      @(negedge CLK);
    end
    hist_req = 1'b0;
    check("clr_busy_cycles", busy_cnt, 48);
    check("clr_zero_writes", zero_wr - z0, 16);
    check("clr_total_writes", wr_count - wr0, 17);
    check("clr_hist_not_in_sweep", ack_in_busy, 1'b0);
    check("clr_hist_latency_after_sweep", ack_cyc - fall_cyc, 6);
    check("clr_word0", mem[0], 16'h0000);
    check("clr_word_last", mem[15], 16'h0000);
    check("clr_word_past_last", mem[16], 16'h1234);
    check("clr_then_hist_word", mem[5], 16'h0001);

    // ---- reset asserted during H_WE ----
    preload(8'h33, 16'h0042);
    @(negedge CLK);
    hist_adr = 8'h33; hist_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!sram_we_n) begin found = 1'b1; break; end
    end
    check("mid_rst_reached_we", found, 1'b1);
    n = hist_acks;
    RSTN = 1'b0;
    #1;
    check("mid_rst_strobes_async", {sram_oe_n, sram_we_n, sram_drv}, 3'b110);
    hist_req = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    repeat (8) @(negedge CLK);
    check("mid_rst_no_ack", hist_acks - n, 0);
    check("mid_rst_word_kept", mem[8'h33], 16'h0042);
    run_op(1'b1, 8'h33, lat);
    check("mid_rst_idle_rd_latency", lat, 4);
    check("mid_rst_idle_rd_data", rd_data, 16'h0042);

    // ---- strobe rules over the whole run ----
    repeat (2) @(negedge CLK);
    check("strobe_overlap_events", ovl, 0);
    check("write_without_drive", drv_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
